// File: rtl/usr_seq.sv
// usr_seq: command sequencer that drives a universal shift register over a valid/ready handshake.
// Registered select/serial/parallel outputs; rotate serial bits come straight from q feedback.
module usr_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       select,
  output logic             s_left,
  output logic             s_right,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [2:0] OP_LOAD = 3'd1, OP_SHR = 3'd2, OP_SHL = 3'd3, OP_ROR = 3'd4, OP_ROL = 3'd5;
  state_t state, state_n;
  logic [2:0] op, op_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_eff;
  logic [WIDTH-1:0] sh_buf, sh_buf_n, par_n;
  logic [1:0] sel_n;
  logic sl, sl_n, sr, sr_n, done_n, ab_n, err_n, ready_n, busy_n, shift_op;
  assign cnt_eff  = (cmd_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_cnt;
  assign shift_op = (cmd_op >= OP_SHR) && (cmd_op <= OP_ROL);
  // rotates feed the bit falling off the far end straight back in
  assign s_right = (state == RUN && op == OP_ROR) ? q_in[0] : sr;
  assign s_left  = (state == RUN && op == OP_ROL) ? q_in[WIDTH-1] : sl;
  always_comb begin
    state_n  = state;
    op_n     = op;
    cnt_n    = cnt;
    sh_buf_n = sh_buf;
    par_n    = par_out;
    sel_n    = 2'b00;
    sl_n     = 1'b0;
    sr_n     = 1'b0;
    done_n   = 1'b0;
    ab_n     = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        op_n     = cmd_op;
        sh_buf_n = cmd_data >> 1;
        if (cmd_op == OP_LOAD) begin
          state_n = RUN;
          sel_n   = 2'b11;
          par_n   = cmd_data;
          cnt_n   = '0;
        end else if (shift_op && cnt_eff != '0) begin
          state_n = RUN;
          cnt_n   = cnt_eff - CNT_W'(1);
          sel_n   = (cmd_op == OP_SHR || cmd_op == OP_ROR) ? 2'b01 : 2'b10;
          sr_n    = (cmd_op == OP_SHR) & cmd_data[0];
          sl_n    = (cmd_op == OP_SHL) & cmd_data[0];
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = cmd_op[2] & cmd_op[1];
        end
      end
      RUN: if (abort || cnt == '0) begin
        state_n = DONE;
        done_n  = 1'b1;
        ab_n    = abort;
      end else begin
        cnt_n    = cnt - CNT_W'(1);
        sel_n    = select;
        sh_buf_n = sh_buf >> 1;
        sr_n     = (op == OP_SHR) & sh_buf[0];
        sl_n     = (op == OP_SHL) & sh_buf[0];
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      cnt       <= '0;
      sh_buf    <= '0;
      par_out   <= '0;
      select    <= 2'b00;
      sl        <= 1'b0;
      sr        <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      cnt       <= cnt_n;
      sh_buf    <= sh_buf_n;
      par_out   <= par_n;
      select    <= sel_n;
      sl        <= sl_n;
      sr        <= sr_n;
      done      <= done_n;
      aborted   <= ab_n;
      err       <= err_n;
      cmd_ready <= ready_n;
      busy      <= busy_n;
    end
  end
endmodule

// File: tb/tb_usr_seq.sv
// tb_usr_seq: drives usr_seq against a behavioural usr plant and a per-cycle expectation schedule.
module tb_usr_seq;
  logic clk = 0, rst_n = 1, cmd_valid = 0, abort = 0;
  logic [2:0] cmd_op = 0, cmd_cnt = 0;
  logic [3:0] cmd_data = 0, q = 0;
  logic cmd_ready, s_left, s_right, busy, done, aborted, err;
  logic [1:0] select;
  logic [3:0] par_out;
  int tests = 0, fails = 0, cyc = 0, t_acc = 0, t0 = 0;
  logic last_ab = 0;
  logic [3:0] seq;
  always #5 clk = ~clk;
  usr_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .abort(abort),
    .q_in(q), .select(select), .s_left(s_left), .s_right(s_right),
    .par_out(par_out), .busy(busy), .done(done), .aborted(aborted), .err(err)
  );
  always @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 0;
    else if (select == 2'b01) q <= {s_right, q[3:1]};
    else if (select == 2'b10) q <= {q[2:0], s_left};
    else if (select == 2'b11) q <= par_out;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction
  // one entry per cycle the sequencer is busy; rot selects a serial bit taken from the register
  typedef struct packed {
    logic [1:0] sel; logic sl, sr; logic [1:0] rot; logic [3:0] par;
    logic busy, done, ab, err, ready;
  } exp_t;
  exp_t sched[$];
  exp_t cur = '0;
  logic [3:0] mq = 0, mpar = 0;
  always @(negedge clk) begin
    exp_t r;
    logic e_sl, e_sr;
    int n;
    if (!rst_n) begin
      sched.delete();
      cur = '0;
      mq = 0;
      mpar = 0;
    end
    e_sr = (cur.rot == 2'd1) ? mq[0] : cur.sr;
    e_sl = (cur.rot == 2'd2) ? mq[3] : cur.sl;
    chk("select", 8'(select), 8'(cur.sel));
    chk("s_left", 8'(s_left), 8'(e_sl));
    chk("s_right", 8'(s_right), 8'(e_sr));
    chk("par_out", 8'(par_out), 8'(mpar));
    chk("busy", 8'(busy), 8'(cur.busy));
    chk("done", 8'(done), 8'(cur.done));
    chk("aborted", 8'(aborted), 8'(cur.ab));
    chk("err", 8'(err), 8'(cur.err));
    chk("cmd_ready", 8'(cmd_ready), 8'(cur.ready));
    chk("q", 8'(q), 8'(mq));
    if (rst_n) begin
      if (cur.sel == 2'b01) mq = {e_sr, mq[3:1]};
      else if (cur.sel == 2'b10) mq = {mq[2:0], e_sl};
      else if (cur.sel == 2'b11) mq = cur.par;
      if (cur.sel != 0 && abort) begin
        sched.delete();
        r = '0; r.busy = 1; r.done = 1; r.ab = 1;
        sched.push_back(r);
      end
      if (!cur.busy && cur.ready && cmd_valid) begin
        n = (cmd_op >= 2 && cmd_op <= 5) ? ((cmd_cnt > 4) ? 4 : int'(cmd_cnt)) : 0;
        if (cmd_op == 1) begin
          r = '0; r.busy = 1; r.sel = 2'b11; r.par = cmd_data;
          sched.push_back(r);
        end
        for (int k = 0; k < n; k++) begin
          r = '0; r.busy = 1;
          r.sel = (cmd_op == 2 || cmd_op == 4) ? 2'b01 : 2'b10;
          r.sr = (cmd_op == 2) ? cmd_data[k] : 1'b0;
          r.sl = (cmd_op == 3) ? cmd_data[k] : 1'b0;
          r.rot = (cmd_op == 4) ? 2'd1 : (cmd_op == 5) ? 2'd2 : 2'd0;
          sched.push_back(r);
        end
        r = '0; r.busy = 1; r.done = 1; r.err = (cmd_op >= 6);
        sched.push_back(r);
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else begin
        cur = '0;
        cur.ready = 1;
      end
      if (cur.sel == 2'b11) mpar = cur.par;
    end
  end
  task automatic issue(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data, input logic hold);
    int i = 0;
    cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_valid = 1;
    @(negedge clk);
    while (!cmd_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b want 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    t_acc = cyc;
    cmd_valid = hold;
  endtask
  task automatic wait_done(input int exp_lat, input string name);
    int i = 0;
    while (!done && i < 20) begin
      @(negedge clk);
      i++;
    end
    last_ab = aborted;
    chk(name, 8'(cyc - t_acc), 8'(exp_lat));
  endtask
  initial begin
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    issue(3'd2, 3'd4, 4'b0110, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("rst_select", 8'(select), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_ready", 8'(cmd_ready), 8'h0);
    chk("rst_sright", 8'(s_right), 8'h0);
    @(posedge clk);
    #1 rst_n = 1;
    issue(3'd1, 3'd0, 4'b1010, 0);
    @(negedge clk);
    chk("load_sel", 8'(select), 8'h3);
    chk("load_par", 8'(par_out), 8'ha);
    wait_done(1, "load_lat");
    chk("load_q", 8'(q), 8'ha);
    issue(3'd2, 3'd4, 4'b0110, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seq[k] = s_right;
    end
    chk("shr_seq", 8'(seq), 8'h6);
    wait_done(4, "shr_lat");
    chk("shr_q", 8'(q), 8'h6);
    @(negedge clk);
    chk("shr_ready_back", 8'(cmd_ready), 8'h1);
    issue(3'd1, 3'd0, 4'b1001, 0);
    wait_done(1, "load2_lat");
    issue(3'd5, 3'd1, 4'b0000, 0);
    @(negedge clk);
    chk("rol_sleft", 8'(s_left), 8'h1);
    wait_done(1, "rol_lat");
    chk("rol_q", 8'(q), 8'h3);
    issue(3'd4, 3'd3, 4'b0000, 0);
    wait_done(3, "ror_lat");
    chk("ror_q", 8'(q), 8'h6);
    issue(3'd3, 3'd4, 4'b0011, 0);
    @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    wait_done(2, "abort_lat");
    chk("abort_flag", 8'(last_ab), 8'h1);
    chk("abort_q", 8'(q), 8'hb);
    @(negedge clk);
    chk("abort_sel_after", 8'(select), 8'h0);
    issue(3'd7, 3'd2, 4'b1111, 0);
    chk("illegal_err", 8'(err), 8'h1);
    wait_done(0, "illegal_lat");
    chk("illegal_q", 8'(q), 8'hb);
    issue(3'd2, 3'd0, 4'b1111, 0);
    wait_done(0, "cnt0_lat");
    chk("cnt0_q", 8'(q), 8'hb);
    issue(3'd3, 3'd7, 4'b0101, 0);
    wait_done(4, "sat_lat");
    chk("sat_q", 8'(q), 8'ha);
    issue(3'd1, 3'd0, 4'b1100, 1);
    t0 = t_acc;
    issue(3'd2, 3'd2, 4'b0011, 0);
    chk("b2b_gap", 8'(t_acc - t0), 8'd3);
    wait_done(2, "b2b_lat");
    chk("b2b_q", 8'(q), 8'hf);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end
endmodule
